// File: rtl/clock_divider_pkg.sv
// Shared constants and phase encoding for the runtime-programmable clock divider.
// Holds no logic, so it adds no latency and has no backpressure behaviour.
package clock_divider_pkg;

    localparam int DIV_W_DEFAULT = 16;
    localparam int MIN_DIV       = 2;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

endpackage

// File: rtl/clkdiv_phase_counter.sv
// Low/high phase FSM with a per-phase cycle counter. boundary is combinational and marks the last enabled high cycle.
// No backpressure: i_en low freezes both the counter and the phase.
module clkdiv_phase_counter
    import clock_divider_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk_20,
    input  logic             reset,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_len_low,
    input  logic [DIV_W-1:0] i_len_high,
    output logic             o_phase,
    output logic             o_phase_nxt,
    output logic             o_boundary
);

    phase_e           r_phase;
    logic [DIV_W-1:0] r_cnt;

    phase_e           w_phase_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_len_cur;
    logic             w_phase_end;

    always_ff @(posedge clk_20) begin
        if (reset) begin
            r_phase <= PH_LOW;
            r_cnt   <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Lengths only change at a boundary, when the counter has just wrapped to 0,
    // so the >= compare never sees a counter beyond the active phase length.
    always_comb begin
        w_len_cur   = (r_phase == PH_LOW) ? i_len_low : i_len_high;
        w_phase_end = (r_cnt >= (w_len_cur - DIV_W'(1)));
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        if (i_en) begin
            if (w_phase_end) begin
                w_cnt_nxt   = '0;
                w_phase_nxt = (r_phase == PH_LOW) ? PH_HIGH : PH_LOW;
            end else begin
                w_cnt_nxt   = r_cnt + DIV_W'(1);
            end
        end
    end

    always_comb begin
        o_phase     = r_phase;
        o_phase_nxt = w_phase_nxt;
        o_boundary  = i_en && (r_phase == PH_HIGH) && w_phase_end;
    end

endmodule

// File: rtl/clock_divider.sv
// Divides clk_20 by a runtime ratio (clamped to >= 2); clk/ratio are flops, new ratios take effect at the period boundary.
// No backpressure: en low freezes the output. CLOCK_DIVIDER_TICK_EN adds a one-cycle tick on each clk rise.
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEFAULT,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_20,
    input  logic             reset,
    input  logic             en,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic             clk,
    output logic [DIV_W-1:0] ratio
`ifdef CLOCK_DIVIDER_TICK_EN
    ,
    output logic             tick
`endif
);

    localparam logic [DIV_W-1:0] MIN_RATIO   = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] RESET_RATIO = (DEFAULT_DIV < MIN_DIV) ? MIN_RATIO : DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] r_ratio;
    logic [DIV_W-1:0] r_pend_val;
    logic             r_pend_vld;
    logic             r_clk;

    logic [DIV_W-1:0] w_value_clamped;
    logic [DIV_W-1:0] w_len_low;
    logic [DIV_W-1:0] w_len_high;
    logic             w_phase;
    logic             w_phase_nxt;
    logic             w_boundary;

    // Odd ratios put the extra cycle in the high phase.
    always_comb begin
        w_value_clamped = (div_value < MIN_RATIO) ? MIN_RATIO : div_value;
        w_len_low       = r_ratio >> 1;
        w_len_high      = r_ratio - w_len_low;
    end

    clkdiv_phase_counter #(
        .DIV_W (DIV_W)
    ) u_phase_counter (
        .clk_20      (clk_20),
        .reset       (reset),
        .i_en        (en),
        .i_len_low   (w_len_low),
        .i_len_high  (w_len_high),
        .o_phase     (w_phase),
        .o_phase_nxt (w_phase_nxt),
        .o_boundary  (w_boundary)
    );

    // A load landing on the boundary cycle wins over any older pending value.
    always_ff @(posedge clk_20) begin
        if (reset) begin
            r_ratio    <= RESET_RATIO;
            r_pend_val <= RESET_RATIO;
            r_pend_vld <= 1'b0;
        end else if (w_boundary) begin
            r_pend_vld <= 1'b0;
            if (div_load) begin
                r_ratio <= w_value_clamped;
            end else if (r_pend_vld) begin
                r_ratio <= r_pend_val;
            end
        end else if (div_load) begin
            r_pend_val <= w_value_clamped;
            r_pend_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk_20) begin
        if (reset) begin
            r_clk <= 1'b0;
        end else if (en) begin
            r_clk <= (w_phase_nxt == PH_HIGH);
        end else begin
            r_clk <= (w_phase == PH_HIGH);
        end
    end

    assign clk   = r_clk;
    assign ratio = r_ratio;

`ifdef CLOCK_DIVIDER_TICK_EN
    logic r_tick;

    always_ff @(posedge clk_20) begin
        if (reset) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= en && (w_phase == PH_LOW) && (w_phase_nxt == PH_HIGH);
        end
    end

    assign tick = r_tick;
`else
    // Without the tick option the design carries no tick output or tick flop.
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Scoreboard bench for clock_divider: a period-position model predicts clk/ratio/tick per cycle.
// Build with CLOCK_DIVIDER_TICK_EN defined to also check the tick output.
module tb_clock_divider;

    localparam int DEF_DIV = 2;

    logic        clk_20 = 1'b0;
    logic        reset;
    logic        en;
    logic        div_load;
    logic [15:0] div_value;
    logic        clk;
    logic [15:0] ratio;
`ifdef CLOCK_DIVIDER_TICK_EN
    logic        tick;
`endif

    always #10 clk_20 = ~clk_20;

    clock_divider #(
        .DIV_W       (16),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk_20    (clk_20),
        .reset     (reset),
        .en        (en),
        .div_load  (div_load),
        .div_value (div_value),
        .clk       (clk),
        .ratio     (ratio)
`ifdef CLOCK_DIVIDER_TICK_EN
        ,
        .tick      (tick)
`endif
    );

    typedef struct {
        logic        clk_e;
        logic [15:0] ratio_e;
        logic        tick_e;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model: position inside the current period, 0..N-1; clk is high for the upper ceil(N/2) positions.
    int unsigned m_n    = 2;
    int unsigned m_pend = 2;
    bit          m_pv   = 1'b0;
    int unsigned m_pos  = 0;

    function automatic int unsigned clampv(input int unsigned v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic l, input logic [15:0] v);
        exp_t x;
        bit   tick_e;
        bit   bnd;
        tick_e = 1'b0;
        if (r) begin
            m_n   = clampv(DEF_DIV);
            m_pv  = 1'b0;
            m_pos = 0;
        end else begin
            bnd = e && (m_pos == m_n - 1);
            if (e) begin
                m_pos++;
                tick_e = (m_pos == m_n / 2);
            end
            if (bnd) begin
                m_pos  = 0;
                tick_e = 1'b0;
                if (l)         m_n = clampv(v);
                else if (m_pv) m_n = m_pend;
                m_pv = 1'b0;
            end else if (l) begin
                m_pend = clampv(v);
                m_pv   = 1'b1;
            end
        end
        x.clk_e   = (m_pos >= m_n / 2);
        x.ratio_e = 16'(m_n);
        x.tick_e  = tick_e;
        sb_q.push_back(x);
    endtask

    task automatic cyc(input logic r, input logic e, input logic l, input logic [15:0] v);
        reset     = r;
        en        = e;
        div_load  = l;
        div_value = v;
        @(posedge clk_20);
        model_step(r, e, l, v);
        #1;
    endtask

    task automatic run_to(input int unsigned n, input int unsigned pos);
        int k;
        k = 0;
        while (!(m_n == n && m_pos == pos) && k < 100) begin
            cyc(1'b0, 1'b1, 1'b0, 16'd0);
            k++;
        end
        chk("run_to_reached", {31'd0, (m_n == n && m_pos == pos)}, 32'd1);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk_20);
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                chk("clk", {31'd0, clk}, {31'd0, x.clk_e});
                chk("ratio", {16'd0, ratio}, {16'd0, x.ratio_e});
`ifdef CLOCK_DIVIDER_TICK_EN
                chk("tick", {31'd0, tick}, {31'd0, x.tick_e});
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_r, r_e, r_l;
        logic [15:0] r_v;
        reset     = 1'b1;
        en        = 1'b0;
        div_load  = 1'b0;
        div_value = '0;

        repeat (5)  cyc(1'b1, 1'b1, 1'b0, 16'd0);
        repeat (12) cyc(1'b0, 1'b1, 1'b0, 16'd0);

        // Load 5 mid-period; takes effect only at the next boundary.
        cyc(1'b0, 1'b1, 1'b1, 16'd5);
        repeat (20) cyc(1'b0, 1'b1, 1'b0, 16'd0);

        cyc(1'b0, 1'b1, 1'b1, 16'd0);
        cyc(1'b0, 1'b1, 1'b1, 16'd1);
        repeat (14) cyc(1'b0, 1'b1, 1'b0, 16'd0);

        // Freeze mid high-phase with N=4.
        cyc(1'b0, 1'b1, 1'b1, 16'd4);
        run_to(4, 2);
        repeat (7)  cyc(1'b0, 1'b0, 1'b0, 16'd0);
        repeat (12) cyc(1'b0, 1'b1, 1'b0, 16'd0);

        // Reset mid high-phase with N=6.
        cyc(1'b0, 1'b1, 1'b1, 16'd6);
        run_to(6, 4);
        cyc(1'b1, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b1, 1'b1, 16'd6);
        repeat (16) cyc(1'b0, 1'b1, 1'b0, 16'd0);

        // Load exactly on the boundary cycle, then a load while disabled.
        run_to(6, 5);
        cyc(1'b0, 1'b1, 1'b1, 16'd3);
        repeat (10) cyc(1'b0, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b1, 16'd7);
        cyc(1'b0, 1'b0, 1'b1, 16'd8);
        repeat (20) cyc(1'b0, 1'b1, 1'b0, 16'd0);

        // Reset has priority over a same-cycle load.
        cyc(1'b1, 1'b1, 1'b1, 16'd9);
        repeat (8) cyc(1'b0, 1'b1, 1'b0, 16'd0);

        cyc(1'b0, 1'b1, 1'b1, 16'd301);
        repeat (700) cyc(1'b0, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b1, 1'b1, 16'hFFFF);
        repeat (40) cyc(1'b0, 1'b1, 1'b0, 16'd0);
        cyc(1'b1, 1'b1, 1'b0, 16'd0);

        repeat (3000) begin
            r_r = ($urandom_range(0, 299) == 0);
            r_e = ($urandom_range(0, 9) < 8);
            r_l = ($urandom_range(0, 19) == 0);
            r_v = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(0, 9));
            cyc(r_r, r_e, r_l, r_v);
        end

        cyc(1'b0, 1'b1, 1'b0, 16'd0);
        repeat (3) @(posedge clk_20);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_divider.md
CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter: DIV_W, 16, width of ratio bus and internal counters.
REQ-003 Parameter: DEFAULT_DIV, 2, divide ratio loaded at reset.
REQ-004 Port: clk_20  input  1  source clock; all logic on its rising edge.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: en  input  1  count enable; low freezes counter and clk output.
REQ-007 Port: div_load  input  1  request to adopt div_value as the new ratio.
REQ-008 Port: div_value  input  DIV_W  requested divide ratio N.
REQ-009 Port: clk  output  1  divided clock, driven directly from a flop (no combinational path).
REQ-010 Port: ratio  output  DIV_W  divide ratio currently in effect.

Function
REQ-011 For effective ratio N: clk low for L=floor(N/2) enabled cycles, then high for H=ceil(N/2) enabled cycles, repeating; period N source cycles.
REQ-012 Odd N SHALL give high phase one cycle longer than low phase; only rising edges of clk_20 are used.
REQ-013 Ratio values 0 and 1 SHALL be clamped to 2; ratio output reports the clamped value.
REQ-014 div_load high on any cycle SHALL capture div_value into a pending register; a later load before adoption overwrites it.
REQ-015 Pending ratio SHALL be adopted only at the period boundary (last high-phase cycle completes); the new period starts with its low phase; no glitch or truncated phase.
REQ-016 div_load coincident with the boundary cycle SHALL be adopted at that same boundary.
REQ-017 en low SHALL hold counter, clk and phase unchanged; div_load is still captured while en is low.
REQ-018 Counter SHALL wrap to 0 at each phase end; never exceeds N-1 for any DIV_W-bit N.

Reset
REQ-019 Reset SHALL force clk=0, counter=0, phase=low, ratio=clamped DEFAULT_DIV, pending load cleared.
REQ-020 Reset mid-period SHALL abort the period; the first cycle after release begins a full low phase.
REQ-021 Reset SHALL take priority over en and div_load in the same cycle.

Configuration
REQ-022 Macro CLOCK_DIVIDER_TICK_EN defined: extra output port tick (1 bit), registered, high for exactly one clk_20 cycle, coinciding with the first cycle clk is high in each period; 0 in reset.
REQ-023 Macro undefined: tick port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-024 Package clock_divider_pkg SHALL hold DIV_W default, MIN_DIV=2 constant and the phase enum (PH_LOW, PH_HIGH).
REQ-025 One sub-module clkdiv_phase_counter SHALL implement the counter/phase FSM (inputs: len_low, len_high, en; outputs: phase, boundary); top holds ratio registers and output flops.

Verification
REQ-026 clk_20 toggling every 10 ns, reset 100 ns, en=1, DEFAULT_DIV=2 -> clk period 40 ns, 50% duty, clk=0 during reset.
REQ-027 Load div_value=5 -> after current period, clk low 2 cycles (40 ns), high 3 cycles (60 ns); ratio reads 5 only from the boundary.
REQ-028 Load div_value=0, then 1 -> ratio=2, clk period 40 ns.
REQ-029 en low for 7 cycles mid high-phase with N=4 -> clk held high; on resumption, remaining high cycles complete; total period 4 enabled cycles.
REQ-030 Assert reset mid high-phase with N=6 -> clk=0 next cycle; after release 3 low then 3 high cycles.
REQ-031 With CLOCK_DIVIDER_TICK_EN, N=3 -> tick one-cycle pulse every 3 cycles, aligned with clk rise; without macro, build passes with tick unconnected.
